uart_rx_param: RTL and testbench

//  Parametrised UART receiver, next generation of the fixed-format receiver.

---
 rtl/uart_rx_param_if.sv | 33 +++
 rtl/uart_rx_param.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx_param.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_param_if.sv
// Receive-side host interface of the parametrised UART receiver.
// Latency: none, this is only a bundle of wires.
// Backpressure: the consumer holds rx_ready low to keep rx_valid/rx_data stable.
//
// Signals:
//   rx_data     received word, meaningful while rx_valid is high
//   rx_valid    word available, held until accepted
//   rx_ready    consumer accepts when rx_valid & rx_ready
//   parity_err  sideband to rx_data, parity mismatch
//   frame_err   sideband to rx_data, stop bit sampled low
//   overrun_err single-cycle pulse, a frame was dropped because the holding register was full
//   break_det   single-cycle pulse, break condition seen on the line
interface uart_rx_param_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic                 parity_err;
   logic                 frame_err;
   logic                 overrun_err;
   logic                 break_det;

   // master = the receiver, slave = the consumer
   modport master (
      output rx_data, rx_valid, parity_err, frame_err, overrun_err, break_det,
      input  rx_ready
   );
   modport slave (
      input  rx_data, rx_valid, parity_err, frame_err, overrun_err, break_det,
      output rx_ready
   );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: NCO baud tick, 2-flop sync, 3-sample majority, framing FSM.
// Latency: rx_valid rises 2 clk after the sample tick of the last stop bit.
// Backpressure: one holding register; a frame completing while it is full is dropped with an overrun pulse.
//
// Ports:
//   clk, rst    single clock, synchronous active-high reset
//   rxd         asynchronous serial input, idle high
//   nco_step    tick rate = nco_step / 2^NCO_W per clk, 0 halts the receiver
//   rx_if       host side (data, valid/ready, error sideband, overrun/break pulses)
module uart_rx_param #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16,
   parameter int NCO_W      = 17
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rxd,
   input  logic [NCO_W-1:0] nco_step,
   uart_rx_param_if.master  rx_if
);
   localparam int             CW        = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0]  HALF      = CW'(OVERSAMPLE / 2);
   localparam logic [3:0]     LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [1:0]     LAST_STOP = 2'(STOP_BITS - 1);
   localparam logic           PAR_ODD   = (PARITY == 2);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DELIVER, S_BREAK
   } state_t;

   state_t                state_q, state_d;
   logic [NCO_W-1:0]      acc_q;
   logic [NCO_W:0]        acc_sum;
   logic                  tick, sample, rx_bit;
   logic [1:0]            sync_q;
   logic [2:0]            win_q;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [3:0]            bcnt_q, bcnt_d;
   logic [1:0]            scnt_q, scnt_d;
   logic [DATA_BITS-1:0]  shift_q, shift_d;
   logic                  par_q, par_d, pbit_q, pbit_d;
   logic                  perr_q, perr_d, ferr_q, ferr_d;
   logic [DATA_BITS-1:0]  data_q, data_d;
   logic                  vld_q, vld_d, pe_q, pe_d, fe_q, fe_d;
   logic                  ovr_q, ovr_d, brk_q, brk_d;

   // Tick is the carry out of the phase accumulator.
   assign acc_sum = {1'b0, acc_q} + {1'b0, nco_step};
   assign tick    = acc_sum[NCO_W];
   assign rx_bit  = (win_q[0] & win_q[1]) | (win_q[0] & win_q[2]) | (win_q[1] & win_q[2]);
   // Counter starts at 0 on leaving IDLE, so the first sample lands half a bit in
   // and it then wraps every OVERSAMPLE ticks to hit the middle of each later bit.
   assign sample  = tick && (cnt_q == HALF);

   always_comb begin
      state_d = state_q;
      cnt_d   = tick ? cnt_q + CW'(1) : cnt_q;
      bcnt_d  = bcnt_q;
      scnt_d  = scnt_q;
      shift_d = shift_q;
      par_d   = par_q;
      pbit_d  = pbit_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      case (state_q)
         S_IDLE: begin
            cnt_d  = '0;
            bcnt_d = '0;
            scnt_d = '0;
            par_d  = 1'b0;
            pbit_d = 1'b0;
            perr_d = 1'b0;
            ferr_d = 1'b0;
            // Gated by tick so a halted NCO really freezes the FSM.
            if (tick && !rx_bit) state_d = S_START;
         end
         S_START: begin
            if (sample) state_d = rx_bit ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (sample) begin
               shift_d = {rx_bit, shift_q[DATA_BITS-1:1]};
               par_d   = par_q ^ rx_bit;
               if (bcnt_q == LAST_DATA) begin
                  bcnt_d  = '0;
                  state_d = (PARITY == 0) ? S_STOP : S_PARITY;
               end else begin
                  bcnt_d = bcnt_q + 4'd1;
               end
            end
         end
         S_PARITY: begin
            if (sample) begin
               pbit_d  = rx_bit;
               perr_d  = ((par_q ^ rx_bit) != PAR_ODD);
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (sample) begin
               if (!rx_bit) begin
                  ferr_d  = 1'b1;
                  // An all-zero frame with a low stop bit is a line break, not data.
                  state_d = (shift_q == '0 && !pbit_q) ? S_BREAK : S_DELIVER;
               end else if (scnt_q == LAST_STOP) begin
                  state_d = S_DELIVER;
               end else begin
                  scnt_d = scnt_q + 2'd1;
               end
            end
         end
         S_DELIVER: state_d = S_IDLE;
         S_BREAK: begin
            if (tick && rx_bit) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Holding register and host-side pulses.
   always_comb begin
      data_d = data_q;
      vld_d  = vld_q;
      pe_d   = pe_q;
      fe_d   = fe_q;
      ovr_d  = 1'b0;
      brk_d  = (state_d == S_BREAK) && (state_q != S_BREAK);
      if (vld_q && rx_if.rx_ready) vld_d = 1'b0;
      if (state_q == S_DELIVER) begin
         if (!vld_q || rx_if.rx_ready) begin
            data_d = shift_q;
            pe_d   = perr_q;
            fe_d   = ferr_q;
            vld_d  = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         sync_q  <= 2'b11;
         win_q   <= 3'b111;
         cnt_q   <= '0;
         bcnt_q  <= '0;
         scnt_q  <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         pbit_q  <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         data_q  <= '0;
         vld_q   <= 1'b0;
         pe_q    <= 1'b0;
         fe_q    <= 1'b0;
         ovr_q   <= 1'b0;
         brk_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_sum[NCO_W-1:0];
         sync_q  <= {sync_q[0], rxd};
         if (tick) win_q <= {win_q[1:0], sync_q[1]};
         cnt_q   <= cnt_d;
         bcnt_q  <= bcnt_d;
         scnt_q  <= scnt_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         pbit_q  <= pbit_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         data_q  <= data_d;
         vld_q   <= vld_d;
         pe_q    <= pe_d;
         fe_q    <= fe_d;
         ovr_q   <= ovr_d;
         brk_q   <= brk_d;
      end
   end

   assign rx_if.rx_data     = data_q;
   assign rx_if.rx_valid    = vld_q;
   assign rx_if.parity_err  = pe_q;
   assign rx_if.frame_err   = fe_q;
   assign rx_if.overrun_err = ovr_q;
   assign rx_if.break_det   = brk_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three receivers (8N1, 8E1, 8N2) on one clock, 64 clk per bit.
// Latency: frames are driven bit by bit; results are gathered by a negedge monitor.
// Backpressure: rx_ready per receiver is driven from the stimulus.
module tb_uart_rx_param;
   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  rxd_v;
   logic [2:0]  rdy_v;
   logic [16:0] nco_step;

   int n_chk  = 0;
   int n_fail = 0;

   uart_rx_param_if #(.DATA_BITS(8)) if0 ();
   uart_rx_param_if #(.DATA_BITS(8)) if1 ();
   uart_rx_param_if #(.DATA_BITS(8)) if2 ();

   assign if0.rx_ready = rdy_v[0];
   assign if1.rx_ready = rdy_v[1];
   assign if2.rx_ready = rdy_v[2];

   uart_rx_param #(.PARITY(0), .STOP_BITS(1)) u_8n1 (
      .clk(clk), .rst(rst), .rxd(rxd_v[0]), .nco_step(nco_step), .rx_if(if0.master));
   uart_rx_param #(.PARITY(1), .STOP_BITS(1)) u_8e1 (
      .clk(clk), .rst(rst), .rxd(rxd_v[1]), .nco_step(nco_step), .rx_if(if1.master));
   uart_rx_param #(.PARITY(0), .STOP_BITS(2)) u_8n2 (
      .clk(clk), .rst(rst), .rxd(rxd_v[2]), .nco_step(nco_step), .rx_if(if2.master));

   always #5 clk = ~clk;

   logic [2:0] vld_w, ovr_w, brk_w, pe_w, fe_w;
   logic [7:0] dat_w [3];
   assign vld_w = {if2.rx_valid, if1.rx_valid, if0.rx_valid};
   assign ovr_w = {if2.overrun_err, if1.overrun_err, if0.overrun_err};
   assign brk_w = {if2.break_det, if1.break_det, if0.break_det};
   assign pe_w  = {if2.parity_err, if1.parity_err, if0.parity_err};
   assign fe_w  = {if2.frame_err, if1.frame_err, if0.frame_err};
   assign dat_w[0] = if0.rx_data;
   assign dat_w[1] = if1.rx_data;
   assign dat_w[2] = if2.rx_data;

   int         hs_cnt [3] = '{0, 0, 0};
   int         vld_cyc[3] = '{0, 0, 0};
   int         ovr_cnt[3] = '{0, 0, 0};
   int         brk_cnt[3] = '{0, 0, 0};
   logic [7:0] last_dat[3] = '{8'h00, 8'h00, 8'h00};
   logic       last_pe [3] = '{1'b0, 1'b0, 1'b0};
   logic       last_fe [3] = '{1'b0, 1'b0, 1'b0};

   // Accepted words and pulses, sampled mid-cycle.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (vld_w[i]) vld_cyc[i]++;
         if (vld_w[i] && rdy_v[i]) begin
            hs_cnt[i]++;
            last_dat[i] = dat_w[i];
            last_pe[i]  = pe_w[i];
            last_fe[i]  = fe_w[i];
         end
         if (ovr_w[i]) ovr_cnt[i]++;
         if (brk_w[i]) brk_cnt[i]++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Bits LSB first, 64 clk each, then two idle bit times.
   task automatic send_bits(input int idx, input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         rxd_v[idx] = bits[i];
         wait_clk(64);
      end
      rxd_v[idx] = 1'b1;
      wait_clk(128);
   endtask

   function automatic logic [15:0] f_8n1(input logic [7:0] d);
      return {6'h3f, 1'b1, d, 1'b0};
   endfunction
   function automatic logic [15:0] f_8p1(input logic [7:0] d, input logic p);
      return {5'h1f, 1'b1, p, d, 1'b0};
   endfunction
   function automatic logic [15:0] f_8n2(input logic [7:0] d, input logic s2);
      return {5'h1f, s2, 1'b1, d, 1'b0};
   endfunction

   int hs0, vc0, ov0, bk0;
   task automatic snap(input int i);
      hs0 = hs_cnt[i]; vc0 = vld_cyc[i]; ov0 = ovr_cnt[i]; bk0 = brk_cnt[i];
   endtask

   initial begin
      rst      = 1'b1;
      rxd_v    = 3'b111;
      rdy_v    = 3'b111;
      nco_step = 17'h08000;
      wait_clk(5);
      rst = 1'b0;
      wait_clk(2);

      check("rst_vld",  {31'd0, if0.rx_valid},    32'd0);
      check("rst_dat",  {24'd0, if0.rx_data},     32'd0);
      check("rst_pe",   {31'd0, if0.parity_err},  32'd0);
      check("rst_fe",   {31'd0, if0.frame_err},   32'd0);
      check("rst_ovr",  {31'd0, if0.overrun_err}, 32'd0);
      check("rst_brk",  {31'd0, if0.break_det},   32'd0);

      // 8N1 0xA5 with ready high: exactly one valid cycle.
      snap(0);
      send_bits(0, f_8n1(8'hA5), 10);
      check("a5_hs",   hs_cnt[0] - hs0, 1);
      check("a5_vcyc", vld_cyc[0] - vc0, 1);
      check("a5_dat",  {24'd0, last_dat[0]}, 32'hA5);
      check("a5_pe",   {31'd0, last_pe[0]}, 0);
      check("a5_fe",   {31'd0, last_fe[0]}, 0);
      check("a5_ovr",  ovr_cnt[0] - ov0, 0);

      // Even parity, 0x07 has three ones so the correct parity bit is 1.
      send_bits(1, f_8p1(8'h07, 1'b0), 11);
      check("par0_dat", {24'd0, last_dat[1]}, 32'h07);
      check("par0_pe",  {31'd0, last_pe[1]}, 1);
      send_bits(1, f_8p1(8'h07, 1'b1), 11);
      check("par1_dat", {24'd0, last_dat[1]}, 32'h07);
      check("par1_pe",  {31'd0, last_pe[1]}, 0);

      // Overrun: second frame dropped while the first is held.
      rdy_v[0] = 1'b0;
      snap(0);
      send_bits(0, f_8n1(8'h11), 10);
      check("ovr_vld1", {31'd0, if0.rx_valid}, 1);
      send_bits(0, f_8n1(8'h22), 10);
      check("ovr_dat",  {24'd0, if0.rx_data}, 32'h11);
      check("ovr_vld2", {31'd0, if0.rx_valid}, 1);
      check("ovr_cnt",  ovr_cnt[0] - ov0, 1);
      rdy_v[0] = 1'b1;
      wait_clk(3);
      check("ovr_hs",   hs_cnt[0] - hs0, 1);
      check("ovr_acc",  {24'd0, last_dat[0]}, 32'h11);
      check("ovr_vld0", {31'd0, if0.rx_valid}, 0);

      // Break: line low for 20 bit times, then a normal frame.
      snap(0);
      rxd_v[0] = 1'b0;
      wait_clk(20 * 64);
      rxd_v[0] = 1'b1;
      wait_clk(128);
      check("brk_cnt",  brk_cnt[0] - bk0, 1);
      check("brk_vcyc", vld_cyc[0] - vc0, 0);
      send_bits(0, f_8n1(8'h5A), 10);
      check("brk_hs",   hs_cnt[0] - hs0, 1);
      check("brk_dat",  {24'd0, last_dat[0]}, 32'h5A);
      check("brk_fe",   {31'd0, last_fe[0]}, 0);

      // 16 clk glitch on an idle line: nothing reported.
      snap(0);
      rxd_v[0] = 1'b0;
      wait_clk(16);
      rxd_v[0] = 1'b1;
      wait_clk(192);
      check("gl_vcyc", vld_cyc[0] - vc0, 0);
      check("gl_brk",  brk_cnt[0] - bk0, 0);
      check("gl_ovr",  ovr_cnt[0] - ov0, 0);
      send_bits(0, f_8n1(8'hC3), 10);
      check("gl_dat",  {24'd0, last_dat[0]}, 32'hC3);

      // Two stop bits: good frame, then second stop low.
      send_bits(2, f_8n2(8'h3C, 1'b1), 11);
      check("st2_ok_dat", {24'd0, last_dat[2]}, 32'h3C);
      check("st2_ok_fe",  {31'd0, last_fe[2]}, 0);
      send_bits(2, f_8n2(8'h3C, 1'b0), 11);
      check("st2_bad_dat", {24'd0, last_dat[2]}, 32'h3C);
      check("st2_bad_fe",  {31'd0, last_fe[2]}, 1);
      check("st2_bad_pe",  {31'd0, last_pe[2]}, 0);

      // Reset mid-byte with a word pending.
      rdy_v[0] = 1'b0;
      snap(0);
      send_bits(0, f_8n1(8'h33), 10);
      check("mr_pend", {31'd0, if0.rx_valid}, 1);
      rxd_v[0] = 1'b0;
      wait_clk(64);
      rxd_v[0] = 1'b1;
      wait_clk(64);
      rxd_v[0] = 1'b0;
      wait_clk(100);
      rst = 1'b1;
      rxd_v[0] = 1'b1;
      wait_clk(3);
      rst = 1'b0;
      wait_clk(1);
      check("mr_vld", {31'd0, if0.rx_valid},    0);
      check("mr_dat", {24'd0, if0.rx_data},     0);
      check("mr_pe",  {31'd0, if0.parity_err},  0);
      check("mr_fe",  {31'd0, if0.frame_err},   0);
      check("mr_ovr", {31'd0, if0.overrun_err}, 0);
      rdy_v[0] = 1'b1;
      wait_clk(256);
      check("mr_nohs", hs_cnt[0] - hs0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
